// File: rtl/flit_demux_if.sv
// Flit demultiplexer bus: one input flit stream and two routed output ports.
// Optional per-port flit counters appear when DEMUX_FLITCNT_EN is defined.
interface flit_demux_if #(
  parameter int DATAW = 65,
  parameter int VCHW  = 0
);
  logic [DATAW:0] idata;
  logic           ivalid;
  logic [VCHW:0]  ivch;
  logic [DATAW:0] odata_0;
  logic           ovalid_0;
  logic [VCHW:0]  ovch_0;
  logic [DATAW:0] odata_1;
  logic           ovalid_1;
  logic [VCHW:0]  ovch_1;
  logic           err;
`ifdef DEMUX_FLITCNT_EN
  logic [15:0]    cnt_0;
  logic [15:0]    cnt_1;
`endif

  modport master (
    output idata, ivalid, ivch,
    input  odata_0, ovalid_0, ovch_0, odata_1, ovalid_1, ovch_1, err
`ifdef DEMUX_FLITCNT_EN
    , input cnt_0, cnt_1
`endif
  );

  modport slave (
    input  idata, ivalid, ivch,
    output odata_0, ovalid_0, ovch_0, odata_1, ovalid_1, ovch_1, err
`ifdef DEMUX_FLITCNT_EN
    , output cnt_0, cnt_1
`endif
  );
endinterface

// File: rtl/flit_demux.sv
// 1:2 wormhole flit demux with per-VC route latching and one registered output stage.
// Define DEMUX_FLITCNT_EN to add saturating per-port forwarded-flit counters.
`ifndef TYPE_NONE
`define TYPE_NONE 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'b10
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b11
`endif

module flit_demux #(
  parameter int DATAW     = 65,
  parameter int VCHW      = 0,
  parameter int ROUTE_BIT = 0
) (
  input logic        clk,
  input logic        rst_,
  flit_demux_if.slave bus
);
  localparam int NVC = 2 ** (VCHW + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} route_state_t;

  route_state_t state_q [NVC];
  logic         port_q  [NVC];

  route_state_t state_d;
  logic         port_d;
  logic         fwd_p0;
  logic         port_p0;
  logic         err_p0;
  logic [1:0]   ftype_p0;

`ifdef DEMUX_FLITCNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign ftype_p0 = bus.idata[DATAW:DATAW-1];

  // Stage p0: decode the incoming flit against its VC's route state
  always_comb begin
    state_d = state_q[bus.ivch];
    port_d  = port_q[bus.ivch];
    fwd_p0  = 1'b0;
    err_p0  = 1'b0;
    if (bus.ivalid) begin
      case (ftype_p0)
        `TYPE_HEAD: begin
          err_p0  = (state_q[bus.ivch] == ACTIVE);
          port_d  = bus.idata[ROUTE_BIT];
          state_d = ACTIVE;
          fwd_p0  = 1'b1;
        end
        `TYPE_DATA: begin
          fwd_p0 = (state_q[bus.ivch] == ACTIVE);
          err_p0 = (state_q[bus.ivch] == IDLE);
        end
        `TYPE_TAIL: begin
          fwd_p0  = (state_q[bus.ivch] == ACTIVE);
          err_p0  = (state_q[bus.ivch] == IDLE);
          state_d = IDLE;
        end
        default: ;
      endcase
    end
    port_p0 = port_d;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) begin
        state_q[v] <= IDLE;
        port_q[v]  <= 1'b0;
      end
    end else if (bus.ivalid) begin
      state_q[bus.ivch] <= state_d;
      port_q[bus.ivch]  <= port_d;
    end
  end

  // Stage p1: registered outputs; data/VC of an unselected port hold to limit toggling
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      bus.odata_0  <= '0;
      bus.ovch_0   <= '0;
      bus.ovalid_0 <= 1'b0;
      bus.odata_1  <= '0;
      bus.ovch_1   <= '0;
      bus.ovalid_1 <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.ovalid_0 <= fwd_p0 & ~port_p0;
      bus.ovalid_1 <= fwd_p0 & port_p0;
      bus.err      <= err_p0;
      if (fwd_p0 && !port_p0) begin
        bus.odata_0 <= bus.idata;
        bus.ovch_0  <= bus.ivch;
      end
      if (fwd_p0 && port_p0) begin
        bus.odata_1 <= bus.idata;
        bus.ovch_1  <= bus.ivch;
      end
    end
  end

`ifdef DEMUX_FLITCNT_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      bus.cnt_0 <= 16'd0;
      bus.cnt_1 <= 16'd0;
    end else begin
      if (bus.ovalid_0) bus.cnt_0 <= sat_inc(bus.cnt_0);
      if (bus.ovalid_1) bus.cnt_1 <= sat_inc(bus.cnt_1);
    end
  end
`endif

endmodule

// File: tb/tb_flit_demux.sv
// Randomized and directed bench for flit_demux with a per-VC packet-route reference model.
module tb_flit_demux;
  localparam int DW   = 65;
  localparam int VCHW = 1;
  localparam int NVC  = 2 ** (VCHW + 1);
  localparam int RB   = 0;
  localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_DATA = 2'b10, T_TAIL = 2'b11;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  flit_demux_if #(.DATAW(DW), .VCHW(VCHW)) bus ();
  flit_demux #(.DATAW(DW), .VCHW(VCHW), .ROUTE_BIT(RB)) dut (.clk(clk), .rst_(rst_), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int tot_v0 = 0, tot_v1 = 0, tot_err = 0;
  logic [DW:0] last_flit;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which VCs have an open packet and where it is routed
  bit          m_open [NVC];
  bit          m_port [NVC];
  logic [DW:0] e_d0 = '0, e_d1 = '0;
  logic [VCHW:0] e_c0 = '0, e_c1 = '0;
  logic        e_v0 = 0, e_v1 = 0, e_err = 0;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) begin m_open[v] = 0; m_port[v] = 0; end
      e_d0 = '0; e_d1 = '0; e_c0 = '0; e_c1 = '0; e_v0 = 0; e_v1 = 0; e_err = 0;
    end else begin
      logic [1:0] t;
      int vc;
      bit go;
      e_v0 = 0; e_v1 = 0; e_err = 0; go = 0;
      if (bus.ivalid === 1'b1) begin
        t  = bus.idata[DW:DW-1];
        vc = int'(bus.ivch);
        if (t == T_HEAD) begin
          e_err = m_open[vc];
          m_open[vc] = 1;
          m_port[vc] = bus.idata[RB];
          go = 1;
        end else if (t == T_DATA || t == T_TAIL) begin
          if (!m_open[vc]) e_err = 1;
          else begin
            go = 1;
            if (t == T_TAIL) m_open[vc] = 0;
          end
        end
        if (go && m_port[vc]) begin e_v1 = 1; e_d1 = bus.idata; e_c1 = bus.ivch; end
        if (go && !m_port[vc]) begin e_v0 = 1; e_d0 = bus.idata; e_c0 = bus.ivch; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ovalid_0", DW'(bus.ovalid_0), DW'(e_v0));
      chk("ovalid_1", DW'(bus.ovalid_1), DW'(e_v1));
      chk("odata_0", bus.odata_0, e_d0);
      chk("odata_1", bus.odata_1, e_d1);
      chk("ovch_0", DW'(bus.ovch_0), DW'(e_c0));
      chk("ovch_1", DW'(bus.ovch_1), DW'(e_c1));
      chk("err", DW'(bus.err), DW'(e_err));
      chk("one_hot", DW'(bus.ovalid_0 & bus.ovalid_1), '0);
      if (bus.ovalid_0 === 1'b1) tot_v0++;
      if (bus.ovalid_1 === 1'b1) tot_v1++;
      if (bus.err === 1'b1) tot_err++;
    end
  end

  task automatic drive(input logic [1:0] t, input logic [31:0] dest, input int vc, input logic v);
    @(negedge clk);
    bus.idata  = {t, (t == T_HEAD) ? 32'h0 : $urandom(), dest};
    bus.ivalid = v;
    bus.ivch   = vc[VCHW:0];
    if (v) last_flit = bus.idata;
  endtask

  task automatic idle();
    drive(T_NONE, 32'h0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.ivalid = 1'b0;
    #1 rst_ = 1'b0;
    #3 rst_ = 1'b1;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  int s0, s1, se;

  initial begin
    bus.idata = '0; bus.ivalid = 1'b0; bus.ivch = '0;
    #1 rst_ = 1'b0;
    #2;
    chk("rst_ovalid_0", DW'(bus.ovalid_0), '0);
    chk("rst_ovalid_1", DW'(bus.ovalid_1), '0);
    chk("rst_odata_1", bus.odata_1, '0);
    chk("rst_err", DW'(bus.err), '0);
    #5 rst_ = 1'b1;
    chk_en = 1;

    // Long packet to port 1
    s0 = tot_v0; s1 = tot_v1; se = tot_err;
    drive(T_HEAD, 32'h09, 0, 1'b1);
    sample();
    chk("head_p1_valid", DW'(bus.ovalid_1), 1);
    chk("head_p1_data", bus.odata_1, {T_HEAD, 32'h0, 32'h09});
    for (int i = 0; i < 20; i++) drive(T_DATA, 32'h0, 0, 1'b1);
    drive(T_TAIL, 32'h0, 0, 1'b1);
    idle(); idle();
    chk("pkt1_p1_count", DW'(tot_v1 - s1), 22);
    chk("pkt1_p0_count", DW'(tot_v0 - s0), 0);
    chk("pkt1_err_count", DW'(tot_err - se), 0);
    drive(T_DATA, 32'h0, 0, 1'b1);
    sample();
    chk("vc0_idle_after_tail", DW'(bus.err), 1);
    idle();

    // Packet to port 0 with ivalid gaps
    drive(T_HEAD, 32'h04, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(T_DATA, 32'h0, 0, 1'b1);
      drive(2'($urandom_range(3)), $urandom(), 0, 1'b0);
    end
    sample();
    chk("gap_hold_data", bus.odata_0, last_flit);
    chk("gap_valid", DW'(bus.ovalid_0), 0);
    drive(T_TAIL, 32'h0, 0, 1'b1);
    idle();

    // Interleaved VCs
    drive(T_HEAD, 32'h09, 0, 1'b1);
    drive(T_HEAD, 32'h04, 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(T_DATA, 32'h0, 0, 1'b1);
      sample();
      chk("ilv_vc0_p1", DW'({bus.ovalid_1, bus.ovch_1}), DW'({1'b1, 2'd0}));
      drive(i == 3 ? T_TAIL : T_DATA, 32'h0, 1, 1'b1);
      sample();
      chk("ilv_vc1_p0", DW'({bus.ovalid_0, bus.ovch_0}), DW'({1'b1, 2'd1}));
    end
    drive(T_TAIL, 32'h0, 0, 1'b1);
    idle();

    // Data on idle VC: single-cycle error, nothing forwarded
    drive(T_DATA, 32'h0, 2, 1'b1);
    sample();
    chk("idle_data_err", DW'({bus.err, bus.ovalid_0, bus.ovalid_1}), DW'(3'b100));
    idle();
    sample();
    chk("idle_data_err_clear", DW'(bus.err), 0);

    // Head while active re-routes
    drive(T_HEAD, 32'h09, 0, 1'b1);
    drive(T_DATA, 32'h0, 0, 1'b1);
    drive(T_HEAD, 32'h04, 0, 1'b1);
    sample();
    chk("rehead_err_p0", DW'({bus.err, bus.ovalid_0, bus.ovalid_1}), DW'(3'b110));
    drive(T_DATA, 32'h0, 0, 1'b1);
    sample();
    chk("rehead_data_p0", DW'({bus.err, bus.ovalid_0}), DW'(2'b01));
    drive(T_TAIL, 32'h0, 0, 1'b1);

    // Asynchronous reset in mid-packet
    drive(T_HEAD, 32'h09, 0, 1'b1);
    drive(T_DATA, 32'h0, 0, 1'b1);
    @(posedge clk);
    #3 rst_ = 1'b0;
    bus.ivalid = 1'b0;
    #1;
    chk("arst_ovalid_1", DW'(bus.ovalid_1), 0);
    chk("arst_odata_1", bus.odata_1, '0);
    chk("arst_ovch_0", DW'(bus.ovch_0), 0);
    @(negedge clk);
    #2 rst_ = 1'b1;
    drive(T_DATA, 32'h0, 0, 1'b1);
    sample();
    chk("arst_data_err", DW'({bus.err, bus.ovalid_0, bus.ovalid_1}), DW'(3'b100));
    drive(T_HEAD, 32'h04, 0, 1'b1);
    sample();
    chk("arst_new_head", DW'({bus.err, bus.ovalid_0}), DW'(2'b01));
    drive(T_TAIL, 32'h0, 0, 1'b1);
    idle();

`ifdef DEMUX_FLITCNT_EN
    do_reset();
    for (int p = 0; p < 10; p++) begin
      drive(T_HEAD, 32'h09, 0, 1'b1);
      for (int i = 0; i < 20; i++) drive(T_DATA, 32'h0, 0, 1'b1);
      drive(T_TAIL, 32'h0, 0, 1'b1);
    end
    idle(); idle();
    chk("cnt_1_220", DW'(bus.cnt_1), 220);
    chk("cnt_0_zero", DW'(bus.cnt_0), 0);
    @(negedge clk);
    force bus.cnt_1 = 16'hFFFE;
    @(negedge clk);
    release bus.cnt_1;
    drive(T_HEAD, 32'h09, 0, 1'b1);
    drive(T_DATA, 32'h0, 0, 1'b1);
    drive(T_TAIL, 32'h0, 0, 1'b1);
    idle(); idle();
    chk("cnt_1_sat", DW'(bus.cnt_1), 16'hFFFF);
`endif

    // Random traffic across all VCs
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] t;
      r = int'($urandom_range(99));
      t = (r < 20) ? T_HEAD : (r < 70) ? T_DATA : (r < 90) ? T_TAIL : T_NONE;
      drive(t, $urandom(), int'($urandom_range(NVC - 1)), ($urandom_range(9) < 8));
      if (i == 1500) do_reset();
    end
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
